// File: rtl/frodo_job_arbiter_pkg.sv
// Shared FrodoKEM main-core definitions: command codes, per-command word
// counts and the arbiter state encoding.
package frodo_job_arbiter_pkg;

    // Width of a main-core command word.
    localparam int MAIN_CMD_SIZE = 4;

    // Main-core command codes.
    localparam logic [MAIN_CMD_SIZE-1:0] MAIN_CMD_SETUPTEST = 4'd1;
    localparam logic [MAIN_CMD_SIZE-1:0] MAIN_CMD_KEYGEN    = 4'd2;
    localparam logic [MAIN_CMD_SIZE-1:0] MAIN_CMD_ENCAPS    = 4'd3;
    localparam logic [MAIN_CMD_SIZE-1:0] MAIN_CMD_DECAPS    = 4'd4;

    // Word counters are wide enough for the longest FrodoKEM-1344 stream.
    localparam int WORD_CNT_W = 14;

    // 64-bit words moved into / out of the core for each command.
    localparam logic [WORD_CNT_W-1:0] MAIN_SETUPTEST_IN_WORDS = 14'd22;
    localparam logic [WORD_CNT_W-1:0] MAIN_SETUPTEST_OUT_WORDS = 14'd0;
    localparam logic [WORD_CNT_W-1:0] MAIN_KEYGEN_IN_WORDS    = 14'd0;
    localparam logic [WORD_CNT_W-1:0] MAIN_KEYGEN_OUT_WORDS   = 14'd5386;
    localparam logic [WORD_CNT_W-1:0] MAIN_ENCAPS_IN_WORDS    = 14'd2690;
    localparam logic [WORD_CNT_W-1:0] MAIN_ENCAPS_OUT_WORDS   = 14'd2716;
    localparam logic [WORD_CNT_W-1:0] MAIN_DECAPS_IN_WORDS    = 14'd8098;
    localparam logic [WORD_CNT_W-1:0] MAIN_DECAPS_OUT_WORDS   = 14'd4;

    // Arbiter job phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RUN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/frodo_job_len.sv
// Combinational lookup from a main-core command to the number of input and
// output words the job will move; unknown codes move nothing.
module frodo_job_len
    import frodo_job_arbiter_pkg::*;
#(
    parameter int CMD_W = MAIN_CMD_SIZE
) (
    input  logic [CMD_W-1:0]      cmd,
    output logic [WORD_CNT_W-1:0] in_len,
    output logic [WORD_CNT_W-1:0] out_len
);

    // Decode the command code into its word counts.
    always_comb begin
        in_len  = '0;
        out_len = '0;
        if (cmd == CMD_W'(MAIN_CMD_SETUPTEST)) begin
            in_len  = MAIN_SETUPTEST_IN_WORDS;
            out_len = MAIN_SETUPTEST_OUT_WORDS;
        end else if (cmd == CMD_W'(MAIN_CMD_KEYGEN)) begin
            in_len  = MAIN_KEYGEN_IN_WORDS;
            out_len = MAIN_KEYGEN_OUT_WORDS;
        end else if (cmd == CMD_W'(MAIN_CMD_ENCAPS)) begin
            in_len  = MAIN_ENCAPS_IN_WORDS;
            out_len = MAIN_ENCAPS_OUT_WORDS;
        end else if (cmd == CMD_W'(MAIN_CMD_DECAPS)) begin
            in_len  = MAIN_DECAPS_IN_WORDS;
            out_len = MAIN_DECAPS_OUT_WORDS;
        end
    end

endmodule

// File: rtl/frodo_job_arbiter.sv
// Shares one FrodoKEM main core between two requesters. A requester owns the
// core for a whole job: one command, then its input and output word streams
// until both word counters drain. Ties are broken round-robin.
module frodo_job_arbiter
    import frodo_job_arbiter_pkg::*;
#(
    parameter int CMD_W = MAIN_CMD_SIZE
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [CMD_W-1:0] r0_cmd,
    input  logic             r0_cmd_isReady,
    output logic             r0_cmd_canReceive,
    input  logic [63:0]      r0_in,
    input  logic             r0_in_isReady,
    output logic             r0_in_canReceive,
    output logic [63:0]      r0_out,
    output logic             r0_out_isReady,
    input  logic             r0_out_canReceive,

    input  logic [CMD_W-1:0] r1_cmd,
    input  logic             r1_cmd_isReady,
    output logic             r1_cmd_canReceive,
    input  logic [63:0]      r1_in,
    input  logic             r1_in_isReady,
    output logic             r1_in_canReceive,
    output logic [63:0]      r1_out,
    output logic             r1_out_isReady,
    input  logic             r1_out_canReceive,

    output logic [CMD_W-1:0] core_cmd,
    output logic             core_cmd_isReady,
    input  logic             core_cmd_canReceive,
    output logic [63:0]      core_in,
    output logic             core_in_isReady,
    input  logic             core_in_canReceive,
    input  logic [63:0]      core_out,
    input  logic             core_out_isReady,
    output logic             core_out_canReceive,

    output logic             busy,
    output logic             grant
);

    arb_state_t            state, state_next;
    logic                  grant_next;
    logic                  last_served, last_next;
    logic [WORD_CNT_W-1:0] in_left, in_next;
    logic [WORD_CNT_W-1:0] out_left, out_next;
    logic [WORD_CNT_W-1:0] job_in_len, job_out_len;

    // Streams of whichever requester currently owns the core.
    logic [CMD_W-1:0]      sel_cmd;
    logic                  sel_cmd_rdy;
    logic [63:0]           sel_in;
    logic                  sel_in_rdy;
    logic                  sel_out_can;
    logic                  in_active, out_active;
    logic                  cmd_hs, in_hs, out_hs;

    assign sel_cmd     = grant ? r1_cmd            : r0_cmd;
    assign sel_cmd_rdy = grant ? r1_cmd_isReady    : r0_cmd_isReady;
    assign sel_in      = grant ? r1_in             : r0_in;
    assign sel_in_rdy  = grant ? r1_in_isReady     : r0_in_isReady;
    assign sel_out_can = grant ? r1_out_canReceive : r0_out_canReceive;

    assign in_active  = (in_left != '0);
    assign out_active = (out_left != '0);

    assign cmd_hs = (state == ST_CMD) && sel_cmd_rdy && core_cmd_canReceive;
    assign in_hs  = (state == ST_RUN) && in_active && sel_in_rdy && core_in_canReceive;
    assign out_hs = (state == ST_RUN) && out_active && core_out_isReady && sel_out_can;

    assign busy = (state != ST_IDLE);

    frodo_job_len #(
        .CMD_W (CMD_W)
    ) u_job_len (
        .cmd     (sel_cmd),
        .in_len  (job_in_len),
        .out_len (job_out_len)
    );

    // Job state, owner, round-robin history and word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
            in_left     <= '0;
            out_left    <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_served <= last_next;
            in_left     <= in_next;
            out_left    <= out_next;
        end
    end

    // Next-state logic and stream routing between owner and core.
    always_comb begin
        state_next          = state;
        grant_next          = grant;
        last_next           = last_served;
        in_next             = in_left;
        out_next            = out_left;
        core_cmd            = '0;
        core_cmd_isReady    = 1'b0;
        core_in             = '0;
        core_in_isReady     = 1'b0;
        core_out_canReceive = 1'b0;
        r0_cmd_canReceive   = 1'b0;
        r1_cmd_canReceive   = 1'b0;
        r0_in_canReceive    = 1'b0;
        r1_in_canReceive    = 1'b0;
        r0_out              = '0;
        r1_out              = '0;
        r0_out_isReady      = 1'b0;
        r1_out_isReady      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (r0_cmd_isReady && r1_cmd_isReady) begin
                    grant_next = ~last_served;
                    state_next = ST_CMD;
                end else if (r0_cmd_isReady) begin
                    grant_next = 1'b0;
                    state_next = ST_CMD;
                end else if (r1_cmd_isReady) begin
                    grant_next = 1'b1;
                    state_next = ST_CMD;
                end
            end

            ST_CMD: begin
                core_cmd         = sel_cmd;
                core_cmd_isReady = sel_cmd_rdy;
                if (grant) r1_cmd_canReceive = core_cmd_canReceive;
                else       r0_cmd_canReceive = core_cmd_canReceive;
                if (cmd_hs) begin
                    in_next  = job_in_len;
                    out_next = job_out_len;
                    if ((job_in_len == '0) && (job_out_len == '0)) begin
                        state_next = ST_IDLE;
                        last_next  = ~last_served;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                core_in             = sel_in;
                core_in_isReady     = sel_in_rdy && in_active;
                core_out_canReceive = sel_out_can && out_active;
                if (grant) begin
                    r1_in_canReceive = core_in_canReceive && in_active;
                    r1_out           = core_out;
                    r1_out_isReady   = core_out_isReady && out_active;
                end else begin
                    r0_in_canReceive = core_in_canReceive && in_active;
                    r0_out           = core_out;
                    r0_out_isReady   = core_out_isReady && out_active;
                end
                in_next  = in_left - WORD_CNT_W'(in_hs);
                out_next = out_left - WORD_CNT_W'(out_hs);
                if ((in_next == '0) && (out_next == '0)) begin
                    state_next = ST_IDLE;
                    last_next  = ~last_served;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frodo_job_arbiter.sv
// Directed bench for frodo_job_arbiter: full-length FrodoKEM jobs from both
// requesters, round-robin ties, stalls, unknown commands and mid-job reset.
module tb_frodo_job_arbiter;
    import frodo_job_arbiter_pkg::*;

    localparam int CMD_W = MAIN_CMD_SIZE;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CMD_W-1:0] r0_cmd = '0, r1_cmd = '0;
    logic             r0_cmd_isReady = 1'b0, r1_cmd_isReady = 1'b0;
    logic             r0_cmd_canReceive, r1_cmd_canReceive;
    logic [63:0]      r0_in = '0, r1_in = '0;
    logic             r0_in_isReady = 1'b0, r1_in_isReady = 1'b0;
    logic             r0_in_canReceive, r1_in_canReceive;
    logic [63:0]      r0_out, r1_out;
    logic             r0_out_isReady, r1_out_isReady;
    logic             r0_out_canReceive = 1'b0, r1_out_canReceive = 1'b0;
    logic [CMD_W-1:0] core_cmd;
    logic             core_cmd_isReady;
    logic             core_cmd_canReceive = 1'b0;
    logic [63:0]      core_in;
    logic             core_in_isReady;
    logic             core_in_canReceive = 1'b0;
    logic [63:0]      core_out = '0;
    logic             core_out_isReady = 1'b0;
    logic             core_out_canReceive;
    logic             busy, grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frodo_job_arbiter #(.CMD_W(CMD_W)) dut (
        .clk(clk), .rst(rst),
        .r0_cmd(r0_cmd), .r0_cmd_isReady(r0_cmd_isReady), .r0_cmd_canReceive(r0_cmd_canReceive),
        .r0_in(r0_in), .r0_in_isReady(r0_in_isReady), .r0_in_canReceive(r0_in_canReceive),
        .r0_out(r0_out), .r0_out_isReady(r0_out_isReady), .r0_out_canReceive(r0_out_canReceive),
        .r1_cmd(r1_cmd), .r1_cmd_isReady(r1_cmd_isReady), .r1_cmd_canReceive(r1_cmd_canReceive),
        .r1_in(r1_in), .r1_in_isReady(r1_in_isReady), .r1_in_canReceive(r1_in_canReceive),
        .r1_out(r1_out), .r1_out_isReady(r1_out_isReady), .r1_out_canReceive(r1_out_canReceive),
        .core_cmd(core_cmd), .core_cmd_isReady(core_cmd_isReady), .core_cmd_canReceive(core_cmd_canReceive),
        .core_in(core_in), .core_in_isReady(core_in_isReady), .core_in_canReceive(core_in_canReceive),
        .core_out(core_out), .core_out_isReady(core_out_isReady), .core_out_canReceive(core_out_canReceive),
        .busy(busy), .grant(grant)
    );

    // Streams a running job for requester r until busy falls (or abort_at input
    // words have moved, when abort_at >= 0), recording what crossed the core.
    task automatic drive_job(input int r, input bit toggle_in, input int out_start,
                             input int abort_at, output int n_in, output int n_out,
                             output int data_err, output int stall_err, output int done_cyc,
                             output int last_in_cyc, output int first_out_cyc,
                             output int last_out_cyc, output bit timed_out);
        logic [63:0] din, dout;
        bit          hs_in, hs_out, gr_in_can;
        n_in = 0; n_out = 0; data_err = 0; stall_err = 0; done_cyc = -1;
        last_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; timed_out = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (abort_at >= 0 && n_in == abort_at) begin
                timed_out = 1'b0;
                done_cyc  = cyc;
                break;
            end
            din  = {$urandom, $urandom};
            dout = {$urandom, $urandom};
            if (r == 0) begin
                r0_in = din; r0_in_isReady = 1'b1; r0_out_canReceive = 1'b1;
            end else begin
                r1_in = din; r1_in_isReady = 1'b1; r1_out_canReceive = 1'b1;
            end
            core_in_canReceive = toggle_in ? (cyc % 2 == 1) : 1'b1;
            core_out_isReady   = (n_in >= out_start);
            core_out           = dout;
            #1;
            hs_in     = core_in_isReady && core_in_canReceive;
            hs_out    = (r == 0) ? (r0_out_isReady && r0_out_canReceive)
                                 : (r1_out_isReady && r1_out_canReceive);
            gr_in_can = (r == 0) ? r0_in_canReceive : r1_in_canReceive;
            if (gr_in_can !== hs_in) data_err++;
            if (hs_in) begin
                n_in++;
                last_in_cyc = cyc;
                if (core_in !== din) data_err++;
            end
            if (hs_out) begin
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (((r == 0) ? r0_out : r1_out) !== dout) data_err++;
            end
            if (r == 0) begin
                if (r1_cmd_canReceive || r1_in_canReceive || r1_out_isReady || (r1_out != 64'd0))
                    stall_err++;
            end else begin
                if (r0_cmd_canReceive || r0_in_canReceive || r0_out_isReady || (r0_out != 64'd0))
                    stall_err++;
            end
            @(posedge clk); #1;
            if (!busy) begin
                timed_out = 1'b0;
                done_cyc  = cyc;
                break;
            end
        end
        if (abort_at < 0) begin
            r0_in_isReady = 1'b0; r1_in_isReady = 1'b0;
            r0_out_canReceive = 1'b0; r1_out_canReceive = 1'b0;
            core_in_canReceive = 1'b0; core_out_isReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, grant, core_cmd_isReady, core_in_isReady, core_out_canReceive} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b grant=%b cmd_rdy=%b in_rdy=%b out_can=%b want all 0",
                     busy, grant, core_cmd_isReady, core_in_isReady, core_out_canReceive);
        end
        checks++;
        if ({r0_cmd_canReceive, r1_cmd_canReceive, r0_in_canReceive, r1_in_canReceive,
             r0_out_isReady, r1_out_isReady} !== 6'b0) begin
            errors++;
            $display("FAIL reset_requester_hs got nonzero requester handshake outputs, want 0");
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_keygen_tie();
        int n_in, n_out, derr, serr, done, lin, fout, lout;
        bit to;
        r0_cmd = MAIN_CMD_KEYGEN; r1_cmd = MAIN_CMD_KEYGEN;
        r0_cmd_isReady = 1'b1; r1_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tie_first_grant got grant=%b busy=%b want grant=0 busy=1", grant, busy);
        end
        checks++;
        if (r0_cmd_canReceive !== 1'b1 || r1_cmd_canReceive !== 1'b0) begin
            errors++;
            $display("FAIL tie_cmd_can got r0=%b r1=%b want r0=1 r1=0", r0_cmd_canReceive, r1_cmd_canReceive);
        end
        @(posedge clk); #1;
        r0_cmd_isReady = 1'b0;
        drive_job(0, 1'b0, 0, -1, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_out != 5386 || n_in != 0) begin
            errors++;
            $display("FAIL keygen_r0_words got in=%0d out=%0d timeout=%0d want in=0 out=5386", n_in, n_out, to);
        end
        checks++;
        if (serr != 0 || derr != 0) begin
            errors++;
            $display("FAIL keygen_r1_stalled got stall_err=%0d data_err=%0d want 0", serr, derr);
        end
        @(posedge clk); #1;
        checks++;
        if (grant !== 1'b1 || core_cmd_isReady !== 1'b1) begin
            errors++;
            $display("FAIL tie_second_grant got grant=%b cmd_rdy=%b want grant=1 cmd_rdy=1", grant, core_cmd_isReady);
        end
        @(posedge clk); #1;
        r1_cmd_isReady = 1'b0;
        drive_job(1, 1'b0, 0, -1, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_out != 5386 || derr != 0 || serr != 0) begin
            errors++;
            $display("FAIL keygen_r1_words got out=%0d derr=%0d serr=%0d timeout=%0d want out=5386 errs 0",
                     n_out, derr, serr, to);
        end
    endtask

    task automatic test_setup();
        int n_in, n_out, derr, serr, done, lin, fout, lout;
        bit to;
        r0_cmd = MAIN_CMD_SETUPTEST; r0_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || core_cmd_isReady !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got busy=%b cmd_rdy=%b want 0 0", busy, core_cmd_isReady);
        end
        @(posedge clk); #1;
        checks++;
        if (core_cmd_isReady !== 1'b1 || core_cmd !== MAIN_CMD_SETUPTEST || grant !== 1'b0) begin
            errors++;
            $display("FAIL setup_cmd_pass got rdy=%b cmd=%0d grant=%b want 1 %0d 0",
                     core_cmd_isReady, core_cmd, grant, MAIN_CMD_SETUPTEST);
        end
        @(posedge clk); #1;
        r0_cmd_isReady = 1'b0;
        drive_job(0, 1'b0, 0, -1, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_in != 22 || n_out != 0 || derr != 0) begin
            errors++;
            $display("FAIL setup_words got in=%0d out=%0d derr=%0d timeout=%0d want in=22 out=0",
                     n_in, n_out, derr, to);
        end
        checks++;
        if (done != lin || lin != 21 || grant !== 1'b0) begin
            errors++;
            $display("FAIL setup_busy_fall got done=%0d last_in=%0d grant=%b want 21 21 0", done, lin, grant);
        end
    endtask

    task automatic test_encaps_toggle();
        int n_in, n_out, derr, serr, done, lin, fout, lout;
        bit to;
        r1_cmd = MAIN_CMD_ENCAPS; r1_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 1'b1 || r1_cmd_canReceive !== 1'b1 || r0_cmd_canReceive !== 1'b0) begin
            errors++;
            $display("FAIL encaps_grant got grant=%b r1_can=%b r0_can=%b want 1 1 0",
                     grant, r1_cmd_canReceive, r0_cmd_canReceive);
        end
        @(posedge clk); #1;
        r1_cmd_isReady = 1'b0;
        drive_job(1, 1'b1, 0, -1, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_in != 2690 || n_out != 2716) begin
            errors++;
            $display("FAIL encaps_words got in=%0d out=%0d timeout=%0d want in=2690 out=2716", n_in, n_out, to);
        end
        checks++;
        if (derr != 0 || serr != 0) begin
            errors++;
            $display("FAIL encaps_data got data_err=%0d stall_err=%0d want 0 0", derr, serr);
        end
    endtask

    task automatic test_decaps_overlap();
        int n_in, n_out, derr, serr, done, lin, fout, lout;
        bit to;
        r0_cmd = MAIN_CMD_DECAPS; r0_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        r0_cmd_isReady = 1'b0;
        drive_job(0, 1'b0, 8097, -1, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_in != 8098 || n_out != 4 || derr != 0) begin
            errors++;
            $display("FAIL decaps_words got in=%0d out=%0d derr=%0d timeout=%0d want in=8098 out=4",
                     n_in, n_out, derr, to);
        end
        checks++;
        if (fout != lin || lout != done || done != 8100) begin
            errors++;
            $display("FAIL decaps_overlap got last_in=%0d first_out=%0d last_out=%0d done=%0d want 8097 8097 8100 8100",
                     lin, fout, lout, done);
        end
    endtask

    task automatic test_unknown_cmd();
        r0_cmd = 4'hF; r0_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (core_cmd_isReady !== 1'b1 || core_cmd !== 4'hF) begin
            errors++;
            $display("FAIL unknown_cmd_pass got rdy=%b cmd=%0d want 1 15", core_cmd_isReady, core_cmd);
        end
        @(posedge clk); #1;
        r0_cmd_isReady = 1'b0;
        r0_in_isReady = 1'b1; core_in_canReceive = 1'b1;
        core_out_isReady = 1'b1; r0_out_canReceive = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || core_cmd_isReady !== 1'b0 || core_in_isReady !== 1'b0 ||
            r0_in_canReceive !== 1'b0 || r0_out_isReady !== 1'b0 || core_out_canReceive !== 1'b0) begin
            errors++;
            $display("FAIL unknown_cmd_idle got busy=%b cmd_rdy=%b in_rdy=%b in_can=%b out_rdy=%b want all 0",
                     busy, core_cmd_isReady, core_in_isReady, r0_in_canReceive, r0_out_isReady);
        end
        r0_in_isReady = 1'b0; core_in_canReceive = 1'b0;
        core_out_isReady = 1'b0; r0_out_canReceive = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midjob();
        int n_in, n_out, derr, serr, done, lin, fout, lout;
        bit to;
        r1_cmd = MAIN_CMD_ENCAPS; r1_cmd_isReady = 1'b1; core_cmd_canReceive = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        r1_cmd_isReady = 1'b0;
        drive_job(1, 1'b0, 0, 1000, n_in, n_out, derr, serr, done, lin, fout, lout, to);
        checks++;
        if (to || n_in != 1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_point got in=%0d busy=%b timeout=%0d want in=1000 busy=1", n_in, busy, to);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 1'b0 || core_in_isReady !== 1'b0 || r1_in_canReceive !== 1'b0 ||
            r1_out_isReady !== 1'b0 || core_out_canReceive !== 1'b0 || r1_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b grant=%b in_rdy=%b in_can=%b out_rdy=%b out_can=%b want all 0",
                     busy, grant, core_in_isReady, r1_in_canReceive, r1_out_isReady, core_out_canReceive);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || core_in_isReady !== 1'b0 || core_cmd_isReady !== 1'b0 || r1_in_canReceive !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b in_rdy=%b cmd_rdy=%b want 0 0 0",
                     busy, core_in_isReady, core_cmd_isReady);
        end
        r0_in_isReady = 1'b0; r1_in_isReady = 1'b0;
        r0_out_canReceive = 1'b0; r1_out_canReceive = 1'b0;
        core_in_canReceive = 1'b0; core_out_isReady = 1'b0;
        r0_cmd = MAIN_CMD_ENCAPS; r1_cmd = MAIN_CMD_ENCAPS;
        r0_cmd_isReady = 1'b1; r1_cmd_isReady = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 1'b0 || busy !== 1'b1 || r1_cmd_canReceive !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tie got grant=%b busy=%b r1_can=%b want 0 1 0",
                     grant, busy, r1_cmd_canReceive);
        end
        r0_cmd_isReady = 1'b0; r1_cmd_isReady = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keygen_tie();
        test_setup();
        test_encaps_toggle();
        test_decaps_overlap();
        test_unknown_cmd();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frodo_job_arbiter.md
FRODO_JOB_ARBITER -- requirements
Module: frodo_job_arbiter

Interface
REQ-001 SHALL have parameter CMD_W, default `MainCMD_SIZE, width of every command port.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have, per requester r in {0,1}: rN_cmd in CMD_W, rN_cmd_isReady in 1, rN_cmd_canReceive out 1 -- command stream from requester r.
REQ-005 SHALL have, per requester: rN_in in 64, rN_in_isReady in 1, rN_in_canReceive out 1 -- input words from requester r.
REQ-006 SHALL have, per requester: rN_out out 64, rN_out_isReady out 1, rN_out_canReceive in 1 -- result words to requester r.
REQ-007 SHALL have core side: core_cmd out CMD_W, core_cmd_isReady out 1, core_cmd_canReceive in 1, core_in out 64, core_in_isReady out 1, core_in_canReceive in 1, core_out in 64, core_out_isReady in 1, core_out_canReceive out 1 -- wired to one main core.
REQ-008 SHALL have busy out 1 (job in flight) and grant out 1 (index of owning requester).

Function
REQ-009 SHALL share one FrodoKEM-1344 core between two requesters with whole-job granularity; a job never interleaves with another.
REQ-010 SHALL complete a word transfer on any stream only on a rising edge where isReady and canReceive are both 1.
REQ-011 SHALL implement states IDLE, CMD, RUN.
REQ-012 In IDLE with one requester asserting cmd_isReady, SHALL register grant to that requester and go to CMD next cycle.
REQ-013 In IDLE with both asserting, SHALL grant the requester not served last (round-robin).
REQ-014 In CMD, SHALL pass the granted rN_cmd/rN_cmd_isReady to core and core_cmd_canReceive back combinationally; the non-granted rN_cmd_canReceive SHALL be 0.
REQ-015 On the CMD handshake, SHALL load in_left/out_left (14-bit word counters) from the command: setupTest 22/0, keygen 0/5386, encaps 2690/2716, decaps 8098/4; any other code 0/0.
REQ-016 After the CMD handshake, SHALL go to RUN if either counter is non-zero, else to IDLE and toggle last-served.
REQ-017 In RUN, SHALL connect granted rN_in to core_in and core_out to granted rN_out combinationally, gating core_in_isReady with in_left!=0 and rN_out_isReady/core_out_canReceive with out_left!=0.
REQ-018 SHALL decrement in_left per input handshake and out_left per output handshake; both may decrement the same cycle.
REQ-019 SHALL leave RUN for IDLE on the edge where the last outstanding counter reaches 0, toggling last-served; a new grant is possible the cycle after.
REQ-020 Non-granted requesters SHALL see all canReceive and out_isReady at 0 at all times; rN_out data SHALL be 0 when not driven.
REQ-021 In IDLE, all core_*_isReady and core_out_canReceive SHALL be 0.
REQ-022 busy SHALL be 1 in CMD and RUN, 0 in IDLE.

Reset
REQ-023 While rst=1: state IDLE, counters 0, grant 0, last-served 1 (requester 0 wins first tie), busy 0, all handshake outputs 0.
REQ-024 rst asserted mid-job SHALL abort the job immediately; no further core handshakes until a new command.

Structure
REQ-025 Command codes and per-command word counts (22, 5386, 2690, 2716, 8098, 4) SHALL live in the shared FrodoKEM main package/header beside `MainCMD_*.
REQ-026 A sub-module frodo_job_len (combinational command -> in/out word count lookup) is natural; all else in one module.

Verification
REQ-027 r0 sends setupTest, 22 words -> core sees 22 in-handshakes, busy falls the edge after the 22nd, grant=0.
REQ-028 r0 and r1 both send keygen in the same IDLE cycle -> r0 served first (5386 out words), then r1; r1 streams stalled (canReceive/isReady 0) throughout r0's job.
REQ-029 r1 encaps with core_in_canReceive toggling every cycle -> exactly 2690 in, 2716 out transfers, data bit-identical to core side.
REQ-030 Decaps where last input and first output handshake coincide -> both counters decrement; job ends after 4th output word.
REQ-031 Unknown command code -> single core cmd handshake, return to IDLE next cycle, no data transfers.
REQ-032 rst pulsed at word 1000 of encaps -> all outputs 0 within the reset, IDLE after; fresh r1 command then accepted with grant=1? No: grant follows REQ-013 with last-served=1, so r0 preferred on tie.
